microgreen_feature_averager: RTL and testbench
==============================================

Name: microgreen_feature_averager

Overview:
- Upstream stage of the microgreen BNN classifier.
- Accepts a serial stream of 4-bit sensor feature samples (height, color, width, stem) and groups them into frames of four.
- Averages 2^LOG2_AVG frames per feature and presents one packed 16-bit feature word with a valid/ready handshake.
- The packed word drives the classifier's feature inputs.

Parameters:
- FEAT_W, 4, bit width of one feature sample.
- NFEAT, 4, features per frame; fixed at 4, not to be overridden.
- LOG2_AVG, 2, log2 of frames averaged per output; legal range 0..4.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  block can accept a sample.
- in_id  in  2  feature index: 0=height, 1=color, 2=width, 3=stem.
- in_data  in  FEAT_W  unsigned sample value.
- out_valid  out  1  averaged feature word valid.
- out_ready  in  1  downstream accepts the word.
- out_feat  out  4*FEAT_W  packed as {stem, width, color, height}; height in [3:0], stem in [15:12].
- err  out  1  sticky protocol error; tied 0 when the optional feature is absent.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n sampled on the rising edge of clk).
- Reset values: out_valid=0, out_feat=0, err=0, all accumulators=0, frame_cnt=0, state=COLLECT. in_ready=1 from the first cycle after reset.
- Accumulators: one per feature, width FEAT_W+LOG2_AVG, unsigned. They cannot overflow: the maximum sum is 15*2^LOG2_AVG.
- frame_cnt: LOG2_AVG bits (1 bit when LOG2_AVG=0, unused). Counts completed frames in the current window.
- in_ready = (state==COLLECT). It is combinational from registered state only.
- State COLLECT:
  - Sample accepted when in_valid && in_ready; then acc[in_id] += in_data.
  - Frame completes when a sample with in_id==3 is accepted.
  - If frame_cnt < 2^LOG2_AVG-1: frame_cnt++ and stay in COLLECT.
  - Otherwise, on the next clk edge: out_feat[i] = (acc[i] including this sample) >> LOG2_AVG (floor), out_valid=1, state=EMIT.
- State EMIT:
  - in_ready=0. in_valid, in_id and in_data are ignored.
  - out_feat and out_valid are held stable until out_valid && out_ready.
  - On handshake: out_valid=0, all acc=0, frame_cnt=0, state=COLLECT; in_ready=1 in the next cycle.
- Latency: out_valid rises 1 cycle after the final stem sample is accepted.
- Throughput: one sample per cycle in COLLECT, plus at least one EMIT cycle per output word.
- out_ready asserted without out_valid has no effect.
- Duplicate or missing ids (feature disabled): samples accumulate as given. Frame boundary is decided solely by in_id==3.
- LOG2_AVG=0: every frame produces an output word; values pass through unchanged.
- out_feat is registered and keeps its last value after the handshake until the next EMIT load.
- Reset asserted mid-frame or during EMIT discards all partial sums and any pending word. No output is produced for that window.

Optional Feature:
- Macro: MICROGREEN_ORDER_CHECK_EN.
- With the macro:
  - An expected-index counter exp_id (2 bits, reset 0) is kept. ids must arrive in the order 0,1,2,3.
  - An accepted sample with in_id != exp_id sets err (sticky until reset) and is discarded.
  - The same mismatch also clears all accumulators, frame_cnt and exp_id, restarting the window.
  - A correct sample increments exp_id, wrapping 3 to 0.
- Without the macro: no exp_id logic; err is constant 0.

Decomposition:
- Package microgreen_pkg:
  - FEAT_W and NFEAT constants.
  - Feature index constants FEAT_HEIGHT=0, FEAT_COLOR=1, FEAT_WIDTH=2, FEAT_STEM=3.
  - Collector state enum {COLLECT, EMIT}.
- Sub-module microgreen_feat_acc:
  - One per feature, four instances.
  - Holds the accumulator and provides add-enable, clear and shifted-average output.
- Top level owns the FSM, frame_cnt, handshake and order check.

Test Plan:
- Reset, then LOG2_AVG=2; send 4 frames with height 7,8,8,9 and color/width/stem constant 15,0,3 -> out_valid 1 cycle after the 4th stem sample; out_feat=16'h30F8.
- Hold out_ready=0 for 10 cycles after out_valid -> out_feat stable, in_ready=0, in_valid samples ignored. Assert out_ready -> in_ready=1 next cycle; the next window starts from zero sums.
- LOG2_AVG=0 build; send frame 1,2,3,4 back-to-back with out_ready=1 -> out_feat=16'h4321 one cycle after the stem sample.
- Assert rst_n=0 after 2 full frames plus a height sample, then send 4 fresh frames of all 5s -> single output 16'h5555; the pre-reset samples do not contribute.
- With MICROGREEN_ORDER_CHECK_EN: send ids 0,2 -> err=1 and the window is cleared. Then 4 correct frames of 10s -> out_feat=16'hAAAA, err stays 1 until reset.

Source files
------------

// File: rtl/microgreen_pkg.sv
// Shared constants and types for the microgreen feature averager.
// Feature indices match the classifier's packed input order, height in the low nibble.
package microgreen_pkg;

    localparam int FEAT_W = 4;
    localparam int NFEAT  = 4;

    localparam logic [1:0] FEAT_HEIGHT = 2'd0;
    localparam logic [1:0] FEAT_COLOR  = 2'd1;
    localparam logic [1:0] FEAT_WIDTH  = 2'd2;
    localparam logic [1:0] FEAT_STEM   = 2'd3;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;

endpackage

// File: rtl/microgreen_feature_averager_if.sv
// Sample-in / feature-word-out bus of the microgreen feature averager.
// Both sides are valid/ready: a transfer happens on a rising clk edge where valid && ready.
interface microgreen_feature_averager_if;
    import microgreen_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_id;
    logic [FEAT_W-1:0]         in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [NFEAT*FEAT_W-1:0]   out_feat;
    logic                      err;
    logic [0:0]                dbg_state;

    modport master (
        output in_valid, in_id, in_data, out_ready,
        input  in_ready, out_valid, out_feat, err, dbg_state
    );

    modport slave (
        input  in_valid, in_id, in_data, out_ready,
        output in_ready, out_valid, out_feat, err, dbg_state
    );

endinterface

// File: rtl/microgreen_feat_acc.sv
// Per-feature accumulator; avg_next is the floor average of the sum including
// the sample being added this cycle, so the top can load it on the final stem sample.
module microgreen_feat_acc
    import microgreen_pkg::*;
#(
    parameter int LOG2_AVG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add_en,
    input  logic              clr,
    input  logic [FEAT_W-1:0] din,
    output logic [FEAT_W-1:0] avg_next
);

    localparam int ACC_W = FEAT_W + LOG2_AVG;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum_next;

    assign sum_next = acc + (add_en ? ACC_W'(din) : '0);
    // Dropping the low LOG2_AVG bits is the divide; width is exactly FEAT_W.
    assign avg_next = sum_next[ACC_W-1:LOG2_AVG];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            acc <= '0;
        end else if (add_en) begin
            acc <= sum_next;
        end
    end

endmodule

// File: rtl/microgreen_feature_averager.sv
// Frames serial feature samples into groups of four and averages 2^LOG2_AVG frames.
// Optional in-order id checking is built with MICROGREEN_ORDER_CHECK_EN defined.
module microgreen_feature_averager
    import microgreen_pkg::*;
#(
    parameter int LOG2_AVG = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    microgreen_feature_averager_if.slave  bus
);

    localparam int FC_W = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
    localparam logic [FC_W-1:0] FC_MAX = FC_W'((1 << LOG2_AVG) - 1);

    localparam logic [0:0] ST_COLLECT = COLLECT;
    localparam logic [0:0] ST_EMIT    = EMIT;

    logic [0:0]                         state;
    logic [FC_W-1:0]                    frame_cnt;
    logic                               out_valid_q;
    logic [NFEAT*FEAT_W-1:0]            out_feat_q;
    logic [NFEAT-1:0][FEAT_W-1:0]       avg_all;
    logic [NFEAT-1:0]                   add_en;

    logic accept;
    logic id_ok;
    logic good;
    logic bad;
    logic frame_done;
    logic handshake;
    logic clr;

    assign bus.in_ready  = (state == ST_COLLECT);
    assign bus.out_valid = out_valid_q;
    assign bus.out_feat  = out_feat_q;
    assign bus.dbg_state = state;

    assign accept     = bus.in_valid && (state == ST_COLLECT);
    assign good       = accept && id_ok;
    assign bad        = accept && !id_ok;
    assign frame_done = good && (bus.in_id == FEAT_STEM);
    assign handshake  = out_valid_q && bus.out_ready;
    assign clr        = handshake || bad;

    for (genvar g = 0; g < NFEAT; g++) begin : g_acc
        assign add_en[g] = good && (bus.in_id == 2'(g));

        microgreen_feat_acc #(
            .LOG2_AVG (LOG2_AVG)
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .add_en   (add_en[g]),
            .clr      (clr),
            .din      (bus.in_data),
            .avg_next (avg_all[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_COLLECT;
            out_valid_q <= 1'b0;
            out_feat_q  <= '0;
            frame_cnt   <= '0;
        end else if (state == ST_COLLECT) begin
            if (bad) begin
                frame_cnt <= '0;
            end else if (frame_done) begin
                if (frame_cnt == FC_MAX) begin
                    out_feat_q  <= avg_all;
                    out_valid_q <= 1'b1;
                    state       <= ST_EMIT;
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
            end
        end else if (handshake) begin
            // out_feat_q intentionally keeps the last word until the next load.
            out_valid_q <= 1'b0;
            frame_cnt   <= '0;
            state       <= ST_COLLECT;
        end
    end

`ifdef MICROGREEN_ORDER_CHECK_EN
    logic [1:0] exp_id;
    logic       err_q;

    assign id_ok   = (bus.in_id == exp_id);
    assign bus.err = err_q;

    // A misordered sample poisons the whole window, so it restarts at height.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_id <= 2'd0;
            err_q  <= 1'b0;
        end else if (accept) begin
            if (!id_ok) begin
                err_q  <= 1'b1;
                exp_id <= 2'd0;
            end else begin
                exp_id <= exp_id + 2'd1;
            end
        end
    end
`else
    assign id_ok   = 1'b1;
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_microgreen_feature_averager.sv
// Directed bench for microgreen_feature_averager: LOG2_AVG=2 and LOG2_AVG=0 instances.
module tb_microgreen_feature_averager;
    import microgreen_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    logic [15:0] held;

    microgreen_feature_averager_if bus2 ();
    microgreen_feature_averager_if bus0 ();

    microgreen_feature_averager #(.LOG2_AVG(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    microgreen_feature_averager #(.LOG2_AVG(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // drivers
    task automatic send2(input logic [1:0] id, input logic [3:0] d);
        bus2.in_valid = 1'b1;
        bus2.in_id    = id;
        bus2.in_data  = d;
        tick();
        bus2.in_valid = 1'b0;
    endtask

    task automatic send0(input logic [1:0] id, input logic [3:0] d);
        bus0.in_valid = 1'b1;
        bus0.in_id    = id;
        bus0.in_data  = d;
        tick();
        bus0.in_valid = 1'b0;
    endtask

    task automatic frame2(input logic [3:0] h, input logic [3:0] c, input logic [3:0] w, input logic [3:0] s);
        send2(FEAT_HEIGHT, h);
        send2(FEAT_COLOR, c);
        send2(FEAT_WIDTH, w);
        send2(FEAT_STEM, s);
    endtask

    task automatic handshake2();
        bus2.out_ready = 1'b1;
        tick();
        bus2.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus2.in_valid = 1'b0; bus2.in_id = 2'd0; bus2.in_data = 4'd0; bus2.out_ready = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_id = 2'd0; bus0.in_data = 4'd0; bus0.out_ready = 1'b0;
        rst_n = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b0 || bus2.out_feat !== 16'h0000 || bus2.in_ready !== 1'b1
            || bus2.err !== 1'b0 || bus2.dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset2 got v=%b f=%h r=%b e=%b s=%b exp v=0 f=0000 r=1 e=0 s=0",
                     bus2.out_valid, bus2.out_feat, bus2.in_ready, bus2.err, bus2.dbg_state);
        end
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.out_feat !== 16'h0000 || bus0.in_ready !== 1'b1 || bus0.err !== 1'b0) begin
            errors++;
            $display("FAIL reset0 got v=%b f=%h r=%b e=%b exp v=0 f=0000 r=1 e=0",
                     bus0.out_valid, bus0.out_feat, bus0.in_ready, bus0.err);
        end
    endtask

    task automatic test_average();
        // heights 7,8,8,9 -> 32/4=8; color 60/4=15; width 0; stem 12/4=3
        exp_q.push_back(16'h30F8);
        frame2(4'd7, 4'd15, 4'd0, 4'd3);
        frame2(4'd8, 4'd15, 4'd0, 4'd3);
        frame2(4'd8, 4'd15, 4'd0, 4'd3);
        send2(FEAT_HEIGHT, 4'd9);
        send2(FEAT_COLOR, 4'd15);
        send2(FEAT_WIDTH, 4'd0);
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got %b exp 0", bus2.out_valid);
        end
        send2(FEAT_STEM, 4'd3);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_feat !== exp_w) begin
            errors++;
            $display("FAIL avg4 got v=%b f=%h exp v=1 f=%h", bus2.out_valid, bus2.out_feat, exp_w);
        end
    endtask

    task automatic test_hold();
        held = 16'h30F8;
        bus2.in_valid = 1'b1;
        bus2.in_id    = FEAT_STEM;
        bus2.in_data  = 4'd15;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            checks++;
            if (bus2.out_valid !== 1'b1 || bus2.out_feat !== held || bus2.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d] got v=%b f=%h r=%b exp v=1 f=%h r=0",
                         i, bus2.out_valid, bus2.out_feat, bus2.in_ready, held);
            end
        end
        bus2.in_valid = 1'b0;
        handshake2();
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b1 || bus2.out_feat !== held) begin
            errors++;
            $display("FAIL release got v=%b r=%b f=%h exp v=0 r=1 f=%h",
                     bus2.out_valid, bus2.in_ready, bus2.out_feat, held);
        end
        // a fresh window of 1s must give exactly 1s
        exp_q.push_back(16'h1111);
        for (int i = 0; i < 4; i++) frame2(4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_feat !== exp_w) begin
            errors++;
            $display("FAIL fresh_window got v=%b f=%h exp v=1 f=%h", bus2.out_valid, bus2.out_feat, exp_w);
        end
        handshake2();
    endtask

    task automatic test_passthrough();
        bus0.out_ready = 1'b1;
        exp_q.push_back(16'h4321);
        send0(FEAT_HEIGHT, 4'd1);
        send0(FEAT_COLOR, 4'd2);
        send0(FEAT_WIDTH, 4'd3);
        send0(FEAT_STEM, 4'd4);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus0.out_valid !== 1'b1 || bus0.out_feat !== exp_w || bus0.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL pass0 got v=%b f=%h r=%b exp v=1 f=%h r=0",
                     bus0.out_valid, bus0.out_feat, bus0.in_ready, exp_w);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pass0_ack got v=%b r=%b exp v=0 r=1", bus0.out_valid, bus0.in_ready);
        end
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        frame2(4'd15, 4'd15, 4'd15, 4'd15);
        frame2(4'd15, 4'd15, 4'd15, 4'd15);
        send2(FEAT_HEIGHT, 4'd15);
        do_reset();
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got v=%b r=%b exp v=0 r=1", bus2.out_valid, bus2.in_ready);
        end
        exp_q.push_back(16'h5555);
        for (int i = 0; i < 4; i++) frame2(4'd5, 4'd5, 4'd5, 4'd5);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_feat !== exp_w) begin
            errors++;
            $display("FAIL after_reset got v=%b f=%h exp v=1 f=%h", bus2.out_valid, bus2.out_feat, exp_w);
        end
        // reset while the word is pending drops it
        do_reset();
        @(negedge clk);
        checks++;
        if (bus2.out_valid !== 1'b0 || bus2.out_feat !== 16'h0000 || bus2.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL emit_reset got v=%b f=%h r=%b exp v=0 f=0000 r=1",
                     bus2.out_valid, bus2.out_feat, bus2.in_ready);
        end
    endtask

`ifdef MICROGREEN_ORDER_CHECK_EN
    task automatic test_order_check();
        send2(FEAT_HEIGHT, 4'd10);
        send2(FEAT_WIDTH, 4'd10);
        @(negedge clk);
        checks++;
        if (bus2.err !== 1'b1) begin
            errors++;
            $display("FAIL order_err got %b exp 1", bus2.err);
        end
        exp_q.push_back(16'hAAAA);
        for (int i = 0; i < 4; i++) frame2(4'd10, 4'd10, 4'd10, 4'd10);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_feat !== exp_w || bus2.err !== 1'b1) begin
            errors++;
            $display("FAIL order_window got v=%b f=%h e=%b exp v=1 f=%h e=1",
                     bus2.out_valid, bus2.out_feat, bus2.err, exp_w);
        end
        handshake2();
        do_reset();
        @(negedge clk);
        checks++;
        if (bus2.err !== 1'b0) begin
            errors++;
            $display("FAIL order_err_reset got %b exp 0", bus2.err);
        end
    endtask
`else
    task automatic test_order_check();
        // unchecked ids accumulate as given: extra height 10 and width 10
        send2(FEAT_HEIGHT, 4'd10);
        send2(FEAT_WIDTH, 4'd10);
        @(negedge clk);
        checks++;
        if (bus2.err !== 1'b0 || bus2.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_order_err got e=%b v=%b exp e=0 v=0", bus2.err, bus2.out_valid);
        end
        exp_q.push_back(16'hACAC);
        for (int i = 0; i < 4; i++) frame2(4'd10, 4'd10, 4'd10, 4'd10);
        @(negedge clk);
        exp_w = exp_q.pop_front();
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_feat !== exp_w || bus2.err !== 1'b0) begin
            errors++;
            $display("FAIL dup_ids got v=%b f=%h e=%b exp v=1 f=%h e=0",
                     bus2.out_valid, bus2.out_feat, bus2.err, exp_w);
        end
        handshake2();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_average();
        test_hold();
        test_passthrough();
        test_reset_mid();
        test_order_check();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
